// File: rtl/grf_pkg.sv
// Shared definitions for the general-purpose register file: default widths,
// register count, the hardwired-zero address and the data/address word types.
package grf_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 2 ** ADDR_W_DEF;
    localparam int REG_ZERO   = 0;

    typedef logic [DATA_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/grf_read_port.sv
// One combinational read port: register 0 reads as zero, a same-cycle write
// to the addressed register is forwarded, otherwise the stored value is muxed out.
module grf_read_port
    import grf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic [(2**ADDR_W)-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                  ra,
    input  logic [ADDR_W-1:0]                  wa,
    input  logic [DATA_W-1:0]                  wd,
    input  logic                               byp_en,
    output logic [DATA_W-1:0]                  rd
);

    always_comb begin
        rd = regs[ra];
        if (ra == ADDR_W'(REG_ZERO)) begin
            rd = '0;
        end else if (byp_en && (wa == ra)) begin
            rd = wd;
        end
    end

endmodule

// File: rtl/grf.sv
// Register file with two combinational read ports, one synchronous write port,
// hardwired-zero register 0 and write-to-read bypass.
module grf
    import grf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              RegWrite,
    input  logic [ADDR_W-1:0] RA1,
    input  logic [ADDR_W-1:0] RA2,
    input  logic [ADDR_W-1:0] WA,
    input  logic [DATA_W-1:0] WD,
    output logic [DATA_W-1:0] RD1,
    output logic [DATA_W-1:0] RD2
);

    localparam int NR = 2 ** ADDR_W;

    logic [NR-1:0][DATA_W-1:0] regs_q;
    logic [NR-1:0][DATA_W-1:0] regs_d;
    logic                      wr_en;

    // Gating with Reset keeps the bypass off while the array is held cleared.
    assign wr_en = Reset & RegWrite;

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (WA != ADDR_W'(REG_ZERO))) begin
            regs_d[WA] = WD;
        end
        regs_d[REG_ZERO] = '0;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            regs_q <= '0;
        end else begin
            regs_q <= regs_d;
        end
    end

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rp1 (
        .regs   (regs_q),
        .ra     (RA1),
        .wa     (WA),
        .wd     (WD),
        .byp_en (wr_en),
        .rd     (RD1)
    );

    grf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_rp2 (
        .regs   (regs_q),
        .ra     (RA2),
        .wa     (WA),
        .wd     (WD),
        .byp_en (wr_en),
        .rd     (RD2)
    );

endmodule

// File: tb/tb_grf.sv
// Self-checking bench for grf: directed phases followed by random traffic,
// compared against a behavioural model of the register contents.
module tb_grf;

    logic        Clock;
    logic        Reset;
    logic        RegWrite;
    logic [4:0]  RA1;
    logic [4:0]  RA2;
    logic [4:0]  WA;
    logic [31:0] WD;
    logic [31:0] RD1;
    logic [31:0] RD2;

    int checks   = 0;
    int failures = 0;

    logic [31:0] model [32];

    grf dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .RegWrite (RegWrite),
        .RA1      (RA1),
        .RA2      (RA2),
        .WA       (WA),
        .WD       (WD),
        .RD1      (RD1),
        .RD2      (RD2)
    );

    initial begin
        Clock = 1'b0;
        forever #5 Clock = ~Clock;
    end

    function automatic logic [31:0] exp_rd(input logic [4:0] a);
        if (a == 5'd0)
            return 32'd0;
        if (Reset && RegWrite && (WA == a))
            return WD;
        return model[a];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
            $error("check %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_reads(input string tag);
        check({tag, "_rd1"}, RD1, exp_rd(RA1));
        check({tag, "_rd2"}, RD2, exp_rd(RA2));
    endtask

    // One rising edge applied to the model, then return at the falling edge.
    task automatic step();
        @(posedge Clock);
        if (Reset && RegWrite && (WA != 5'd0))
            model[WA] = WD;
        @(negedge Clock);
    endtask

    task automatic clear_model();
        for (int k = 0; k < 32; k++)
            model[k] = 32'd0;
    endtask

    initial begin
        clear_model();
        Reset    = 1'b0;
        RegWrite = 1'b0;
        RA1 = 5'd0; RA2 = 5'd0; WA = 5'd0; WD = 32'd0;

        // Reset held low: writes and bypass must be suppressed.
        @(negedge Clock);
        RegWrite = 1'b1; WA = 5'd3; WD = 32'hDEAD_BEEF; RA1 = 5'd3; RA2 = 5'd3;
        #1;
        check("in_reset_bypass_rd1", RD1, 32'd0);
        check("in_reset_bypass_rd2", RD2, 32'd0);
        step();
        check("in_reset_write_rd1", RD1, 32'd0);
        RegWrite = 1'b0;
        Reset    = 1'b1;

        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i); RA2 = 5'(31 - i);
            #1;
            check($sformatf("post_reset_%0d_rd1", i), RD1, 32'd0);
            check($sformatf("post_reset_%0d_rd2", i), RD2, 32'd0);
        end

        // Write sweep with RA1=5, RA2=6 held.
        RegWrite = 1'b1; RA1 = 5'd5; RA2 = 5'd6;
        for (int i = 0; i < 32; i++) begin
            WA = 5'(i); WD = 32'(i + 1);
            #1;
            check_reads($sformatf("wsweep_%0d", i));
            if (i == 5) check("wsweep_bypass5", RD1, 32'd6);
            if (i == 6) check("wsweep_bypass6", RD2, 32'd7);
            step();
        end
        RegWrite = 1'b0;
        #1;
        check("wsweep_hold_rd1", RD1, 32'd6);
        check("wsweep_hold_rd2", RD2, 32'd7);

        // Disabled writes leave contents alone.
        WA = 5'd5; WD = 32'd100;
        #1;
        check("nowrite_a_rd1", RD1, 32'd6);
        step();
        WA = 5'd6; WD = 32'd200;
        #1;
        check("nowrite_b_rd2", RD2, 32'd7);
        step();
        check("nowrite_c_rd1", RD1, 32'd6);
        check("nowrite_c_rd2", RD2, 32'd7);

        // Read sweep against absolute expectations.
        for (int i = 0; i < 16; i++) begin
            RA1 = 5'(i); RA2 = 5'(31 - i);
            #1;
            check($sformatf("rsweep_%0d_rd1", i), RD1, (i == 0) ? 32'd0 : 32'(i + 1));
            check($sformatf("rsweep_%0d_rd2", i), RD2, 32'(32 - i));
            step();
        end

        // Asynchronous reset mid-cycle.
        RA1 = 5'd16; RA2 = 5'd15;
        #2;
        Reset = 1'b0;
        clear_model();
        #1;
        check("async_reset_rd1", RD1, 32'd0);
        check("async_reset_rd2", RD2, 32'd0);
        for (int i = 16; i < 32; i++) begin
            RA1 = 5'(i); RA2 = 5'(31 - i);
            #1;
            check($sformatf("in_reset_%0d_rd1", i), RD1, 32'd0);
            check($sformatf("in_reset_%0d_rd2", i), RD2, 32'd0);
        end
        step();
        Reset = 1'b1;
        step();
        for (int i = 0; i < 32; i++) begin
            RA1 = 5'(i); RA2 = 5'(31 - i);
            #1;
            check($sformatf("after_rel_%0d_rd1", i), RD1, 32'd0);
            check($sformatf("after_rel_%0d_rd2", i), RD2, 32'd0);
        end

        // Write to register 0 is discarded.
        RegWrite = 1'b1; WA = 5'd0; WD = 32'hFFFF_FFFF; RA1 = 5'd0; RA2 = 5'd0;
        #1;
        check("r0_same_cycle", RD1, 32'd0);
        step();
        RegWrite = 1'b0;
        #1;
        check("r0_after_edge", RD1, 32'd0);

        // Random traffic against the model, with occasional address collisions.
        for (int n = 0; n < 400; n++) begin
            RegWrite = ($urandom_range(0, 3) != 0);
            WA = 5'($urandom_range(0, 31));
            WD = $urandom;
            RA1 = ($urandom_range(0, 3) == 0) ? WA : 5'($urandom_range(0, 31));
            RA2 = ($urandom_range(0, 3) == 0) ? WA : 5'($urandom_range(0, 31));
            #1;
            check_reads($sformatf("rand_%0d", n));
            step();
            RegWrite = 1'b0;
            #1;
            check_reads($sformatf("rand_post_%0d", n));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/grf.md
Name: grf

Overview:
- General-purpose register file for the MIPS-style CPU core: 2^ADDR_W registers of DATA_W bits each.
- Two combinational read ports and one synchronous write port.
- Register 0 is hardwired to zero.
- Sits between the decode stage (reads) and the write-back stage (write), with internal write-to-read bypass so a same-cycle write is visible to readers.

Parameters:
DATA_W, 32, register and data width in bits
ADDR_W, 5, register address width; register count = 2^ADDR_W (32)

Ports:
Clock  input  1  system clock; all state updates on its rising edge
Reset  input  1  asynchronous, active-low reset; clears all registers
RegWrite  input  1  write enable, sampled at rising Clock
RA1  input  ADDR_W  read address, port 1
RA2  input  ADDR_W  read address, port 2
WA  input  ADDR_W  write address
WD  input  DATA_W  write data
RD1  output  DATA_W  read data, port 1 (combinational)
RD2  output  DATA_W  read data, port 2 (combinational)

Behaviour:
- Reset:
  - Reset falling to 0 clears every register to 0 immediately, with no Clock needed.
  - While Reset=0, writes are ignored and RD1/RD2 read 0.
  - Reset release is synchronous-safe: the first write is honoured at the first rising Clock with Reset=1.
- Write:
  - At rising Clock, if Reset=1 and RegWrite=1 and WA!=0, then reg[WA] <= WD.
  - Latency is 1 edge.
  - RegWrite=0 leaves all registers unchanged regardless of WA/WD.
- Register 0:
  - Writes to WA=0 are discarded.
  - Reading address 0 always returns 0.
- Read (per port n in {1,2}), combinational, priority order:
  - (a) RAn==0 -> 0
  - (b) Reset=1 and RegWrite=1 and WA==RAn -> WD (write-through bypass)
  - (c) otherwise -> reg[RAn]
- Port independence: both ports may address the same register, or the write address, in the same cycle; each gets an identical result.
- Outputs track address changes with no clock; data written at edge k is returned from edge k onward, and through the bypass before edge k.
- No X propagation: all registers hold defined values after reset; unknown addresses are not possible (full decode of ADDR_W bits).

Decomposition:
- Shared package holds:
  - DATA_W/ADDR_W defaults
  - NUM_REGS = 2**ADDR_W
  - REG_ZERO = 0 address constant
  - typedef for the data word and register address
- One natural sub-module: grf_read_port, implementing the zero-check, bypass and array mux.
  - Instantiated twice (RA1/RD1, RA2/RD2).
  - Inputs: the register-array view, WA, WD and the bypass-enable signal.

Test Plan:
- Reset low at t=0, then high; read all 32 addresses on both ports -> RD1=RD2=0 everywhere.
- RegWrite=1, for i=0..31 set WA=i and WD=i+1, one cycle each, with RA1=5 and RA2=6 held:
  - RD1 becomes 6 when WA=5 (bypass, same cycle) and stays 6.
  - RD2 becomes 7 when WA=6.
  - Afterwards reg0=0 and reg k = k+1 for k=1..31.
- RegWrite=0, WA=5/WD=100 then WA=6/WD=200 across two edges -> RD1 stays 6, RD2 stays 7; no register changes.
- Sweep RA1=i, RA2=31-i for i=0..15:
  - RD1 = (i==0 ? 0 : i+1)
  - RD2 = (31-i)+1, e.g. i=0 gives RD2=32 and i=15 gives RD2=17.
- At i=16, drive Reset=0 mid-cycle, asynchronous to Clock:
  - RD1/RD2 go to 0 immediately.
  - Sweep i=16..31 -> all reads 0.
  - After release, reads remain 0 until rewritten.
- Write 0xFFFFFFFF to WA=0 with RegWrite=1 -> RD1 with RA1=0 reads 0 both same-cycle and after the edge.
